// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage. Holds the PC, requests instructions from
//               instruction memory over a req/ready handshake, registers the
//               returned word and presents it (with op/funct3/funct7 slices)
//               for exactly one issue cycle. The next PC comes from
//               PCSrc/PCTarget. The unit traps, and stays trapped until
//               reset, on a misaligned branch target, a non-32-bit encoding
//               or a memory timeout.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high reset
//   PCSrc        in   1   take PCTarget as next PC (sampled in ISSUE only)
//   PCTarget     in   32  branch/jump target address
//   imem_req     out  1   instruction memory request
//   imem_addr    out  32  fetch address (= PC)
//   imem_ready   in   1   memory accepts request; imem_rdata valid same cycle
//   imem_rdata   in   32  instruction word
//   instr_valid  out  1   Instr valid; downstream executes this cycle
//   Instr        out  32  registered instruction
//   op           out  7   Instr[6:0]
//   funct3       out  3   Instr[14:12]
//   funct7       out  1   Instr[30]
//   PC           out  32  address of Instr
//   PCPlus4      out  32  PC + 4, modulo 2^32
//   trap         out  1   sticky fault flag
//   trap_cause   out  2   01 misaligned target, 10 imem timeout, 11 bad encoding
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_FETCH = 2'd1;
    localparam logic [1:0]  c_ST_ISSUE = 2'd2;
    localparam logic [1:0]  c_ST_TRAP  = 2'd3;

    localparam logic [1:0]  c_CAUSE_NONE     = 2'b00;
    localparam logic [1:0]  c_CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]  c_CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0]  c_CAUSE_BADENC   = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    // The counter only has to reach TIMEOUT_CYC-1.
    localparam int c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic [1:0]         r_cause;
    logic [c_CNT_W-1:0] r_wait_cnt;

    logic [31:0]        w_pc_plus4;
    logic               w_timeout;
    logic               w_bad_enc;
    logic               w_misalign;
    logic               w_issue_trap;
    logic               w_imem_req;
    logic               w_instr_valid;
    logic               w_trap;

    assign w_pc_plus4   = r_pc + 32'd4;
    // Only 32-bit encodings (low two bits 11) are supported.
    assign w_bad_enc    = (r_instr[1:0] != 2'b11);
    assign w_misalign   = PCSrc && (PCTarget[1:0] != 2'b00);
    assign w_issue_trap = w_bad_enc || w_misalign;

    // Timeout fires on the last permitted non-ready FETCH cycle; a zero
    // TIMEOUT_CYC disables it so the unit waits for memory forever.
    generate
        if (TIMEOUT_CYC != 0) begin : g_timeout_on
            localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
            assign w_timeout = (r_wait_cnt == c_WAIT_LAST);
        end else begin : g_timeout_off
            assign w_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                w_next_state = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                // imem_req is always high in FETCH, so ready alone means accept.
                if (imem_ready) begin
                    w_next_state = c_ST_ISSUE;
                end else if (w_timeout) begin
                    w_next_state = c_ST_TRAP;
                end
            end
            c_ST_ISSUE: begin
                w_next_state = w_issue_trap ? c_ST_TRAP : c_ST_FETCH;
            end
            c_ST_TRAP: begin
                w_next_state = c_ST_TRAP;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_imem_req    = 1'b0;
        w_instr_valid = 1'b0;
        w_trap        = 1'b0;
        case (r_state)
            c_ST_FETCH: w_imem_req    = 1'b1;
            c_ST_ISSUE: w_instr_valid = 1'b1;
            c_ST_TRAP:  w_trap        = 1'b1;
            default:    ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: PC, instruction register, wait counter, trap cause
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_instr    <= c_NOP;
            r_cause    <= c_CAUSE_NONE;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (imem_ready) begin
                        r_instr    <= imem_rdata;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (w_timeout) begin
                            r_cause <= c_CAUSE_TIMEOUT;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    // A faulting instruction leaves the PC pointing at itself.
                    if (w_bad_enc) begin
                        r_cause <= c_CAUSE_BADENC;
                    end else if (w_misalign) begin
                        r_cause <= c_CAUSE_MISALIGN;
                    end else begin
                        r_pc <= PCSrc ? PCTarget : w_pc_plus4;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_req    = w_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = w_instr_valid;
    assign Instr       = r_instr;
    assign op          = r_instr[6:0];
    assign funct3      = r_instr[14:12];
    assign funct7      = r_instr[30];
    assign PC          = r_pc;
    assign PCPlus4     = w_pc_plus4;
    assign trap        = w_trap;
    assign trap_cause  = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Randomised scoreboard bench for instr_fetch_unit. A driver
//               plays instruction memory and branch unit, keeps an
//               architectural PC model and queues expected issues; a monitor
//               pops and compares whenever the DUT issues or traps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_WRAP_PC  = 32'hFFFF_FFFC;
    localparam int          c_TIMEOUT  = 16;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [31:0] c_ADDI     = 32'h0050_0093;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } issue_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT
    logic        reset;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        trap;
    logic [1:0]  trap_cause;

    // Wrap-around DUT (RESET_PC at the top of the address space)
    logic        reset_w;
    logic        pcsrc_w;
    logic [31:0] pctarget_w;
    logic        req_w;
    logic [31:0] addr_w;
    logic        ready_w;
    logic [31:0] rdata_w;
    logic        valid_w;
    logic [31:0] instr_w;
    logic [6:0]  op_w;
    logic [2:0]  funct3_w;
    logic        funct7_w;
    logic [31:0] pc_w;
    logic [31:0] pcplus4_w;
    logic        trap_w;
    logic [1:0]  cause_w;

    instr_fetch_unit #(.RESET_PC(c_RESET_PC), .TIMEOUT_CYC(c_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .Instr(Instr),
        .op(op), .funct3(funct3), .funct7(funct7), .PC(PC), .PCPlus4(PCPlus4),
        .trap(trap), .trap_cause(trap_cause)
    );

    instr_fetch_unit #(.RESET_PC(c_WRAP_PC), .TIMEOUT_CYC(c_TIMEOUT)) dut_wrap (
        .clk(clk), .reset(reset_w), .PCSrc(pcsrc_w), .PCTarget(pctarget_w),
        .imem_req(req_w), .imem_addr(addr_w), .imem_ready(ready_w),
        .imem_rdata(rdata_w), .instr_valid(valid_w), .Instr(instr_w),
        .op(op_w), .funct3(funct3_w), .funct7(funct7_w), .PC(pc_w), .PCPlus4(pcplus4_w),
        .trap(trap_w), .trap_cause(cause_w)
    );

    assign pcsrc_w    = 1'b0;
    assign pctarget_w = 32'h0;
    assign ready_w    = 1'b1;
    assign rdata_w    = c_ADDI;

    // Scoreboard / reference model state
    int          n_tests = 0;
    int          n_fail  = 0;
    issue_t      issue_q[$];
    logic [31:0] model_pc;
    bit          exp_trap;
    logic [1:0]  exp_cause;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 39));
        if (r < 28) return r % 3;
        if (r < 33) return 5;
        if (r < 37) return c_TIMEOUT - 1;   // accepted on the last allowed cycle
        return 30;                          // never ready -> timeout
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        int r;
        w = $urandom;
        r = int'($urandom_range(0, 15));
        if (r == 0) return 32'h0000_0000;
        if (r == 1) begin
            w[1:0] = w[2] ? 2'b01 : 2'b10;
            return w;
        end
        if (r == 2) return c_ADDI;
        w[1:0] = 2'b11;
        return w;
    endfunction

    function automatic logic [31:0] gen_target();
        logic [31:0] t;
        int r;
        t = $urandom;
        r = int'($urandom_range(0, 15));
        if (r == 0) begin
            t[1:0] = t[2] ? 2'b01 : 2'b11;
            return t;
        end
        if (r == 1) return 32'h0000_0102;
        if (r == 2) return 32'hFFFF_FFFC;
        if (r == 3) return 32'h0000_0100;
        t[1:0] = 2'b00;
        return t;
    endfunction

    // Assert reset for one edge (abandoning whatever was in flight) and check
    // the reset state.
    task automatic apply_reset();
        reset      = 1'b1;
        imem_ready = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        PCSrc      = 1'($urandom_range(0, 1));
        PCTarget   = $urandom;
        @(negedge clk);
        chk("rst_imem_req",    32'(imem_req),    32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_Instr",       Instr,            c_NOP);
        chk("rst_op",          32'(op),          32'h13);
        chk("rst_trap",        32'(trap),        32'd0);
        chk("rst_trap_cause",  32'(trap_cause),  32'd0);
        chk("rst_PC",          PC,               c_RESET_PC);
        chk("rst_imem_addr",   imem_addr,        c_RESET_PC);
        chk("rst_PCPlus4",     PCPlus4,          c_RESET_PC + 32'd4);
        issue_q.delete();
        model_pc  = c_RESET_PC;
        exp_trap  = 1'b0;
        exp_cause = 2'b00;
        reset     = 1'b0;
    endtask

    // Driver: plays memory with random latency, random branch requests every
    // cycle (only the ISSUE-cycle values may matter) and steps the PC model.
    task automatic run_episode(input int budget);
        bit          fetching;
        bit          expect_issue;
        int          nrdy;
        int          lat;
        int          tw;
        int          n_acc;
        logic [31:0] last_word;
        logic [31:0] word;
        issue_t      e;
        fetching     = 1'b0;
        expect_issue = 1'b0;
        nrdy         = 0;
        lat          = 0;
        tw           = 0;
        n_acc        = 0;
        last_word    = c_NOP;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (exp_trap) begin
                tw++;
                imem_ready = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
                PCSrc      = 1'($urandom_range(0, 1));
                PCTarget   = gen_target();
                if (tw == 1) chk("trap_rise", 32'(trap), 32'd1);
                if (tw >= 4) break;
                continue;
            end
            if (expect_issue) begin
                chk("issue_after_accept", 32'(instr_valid), 32'd1);
                expect_issue = 1'b0;
            end
            PCSrc    = ($urandom_range(0, 2) == 0);
            PCTarget = gen_target();
            if (instr_valid) begin
                if (last_word[1:0] != 2'b11) begin
                    exp_cause = 2'b11;
                    exp_trap  = 1'b1;
                end else if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
                    exp_cause = 2'b01;
                    exp_trap  = 1'b1;
                end else begin
                    model_pc = PCSrc ? PCTarget : model_pc + 32'd4;
                end
            end
            if (imem_req) begin
                if (!fetching) begin
                    fetching = 1'b1;
                    nrdy     = 0;
                    lat      = pick_lat();
                end
                chk("imem_addr", imem_addr, model_pc);
                if (nrdy == lat) begin
                    word       = gen_word();
                    imem_ready = 1'b1;
                    imem_rdata = word;
                    last_word  = word;
                    e.pc       = model_pc;
                    e.instr    = word;
                    issue_q.push_back(e);
                    fetching     = 1'b0;
                    expect_issue = 1'b1;
                    n_acc++;
                end else begin
                    imem_ready = 1'b0;
                    imem_rdata = $urandom;
                    nrdy++;
                    if (nrdy == c_TIMEOUT) begin
                        exp_cause = 2'b10;
                        exp_trap  = 1'b1;
                        fetching  = 1'b0;
                    end
                end
            end else begin
                if (fetching) chk("req_held", 32'(imem_req), 32'd1);
                fetching   = 1'b0;
                imem_ready = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
            end
        end
        chk("fetch_progress", (n_acc > 0 || exp_trap) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Monitor: compares every issue and every trap cycle against the model.
    initial begin : monitor
        issue_t e;
        forever begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                if (issue_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_issue: instr_valid=1 got, 0 expected (no accepted fetch) t=%0t", $time);
                end else begin
                    e = issue_q.pop_front();
                    chk("Instr",   Instr,          e.instr);
                    chk("op",      32'(op),        32'(e.instr[6:0]));
                    chk("funct3",  32'(funct3),    32'(e.instr[14:12]));
                    chk("funct7",  32'(funct7),    32'(e.instr[30]));
                    chk("PC",      PC,             e.pc);
                    chk("PCPlus4", PCPlus4,        e.pc + 32'd4);
                    chk("issue_req_low", 32'(imem_req), 32'd0);
                end
            end
            if (trap === 1'b1) begin
                chk("trap_expected",    32'(exp_trap),    32'd1);
                chk("trap_cause",       32'(trap_cause),  32'(exp_cause));
                chk("trap_req_low",     32'(imem_req),    32'd0);
                chk("trap_valid_low",   32'(instr_valid), 32'd0);
                chk("trap_pc_held",     PC,               model_pc);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        reset_w    = 1'b1;
        PCSrc      = 1'b0;
        PCTarget   = 32'h0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        model_pc   = c_RESET_PC;
        exp_trap   = 1'b0;
        exp_cause  = 2'b00;

        // Wrap-around DUT: always-ready memory, fetch at 0xFFFFFFFC then 0.
        @(negedge clk);
        reset_w = 1'b0;
        @(negedge clk);
        chk("wrap_req1",     32'(req_w),   32'd1);
        chk("wrap_addr1",    addr_w,       c_WRAP_PC);
        @(negedge clk);
        chk("wrap_valid",    32'(valid_w), 32'd1);
        chk("wrap_Instr",    instr_w,      c_ADDI);
        chk("wrap_op",       32'(op_w),    32'h13);
        chk("wrap_funct3",   32'(funct3_w), 32'd0);
        chk("wrap_PC",       pc_w,         c_WRAP_PC);
        chk("wrap_PCPlus4",  pcplus4_w,    32'h0000_0000);
        @(negedge clk);
        chk("wrap_req2",     32'(req_w),   32'd1);
        chk("wrap_addr2",    addr_w,       32'h0000_0000);
        chk("wrap_no_trap",  32'(trap_w),  32'd0);

        // Random episodes on the main DUT; each ends by trap or by a reset
        // landing at an arbitrary point (often mid-wait).
        for (int ep = 0; ep < 60; ep++) begin
            apply_reset();
            run_episode(int'($urandom_range(25, 90)));
        end
        apply_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
